instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0040_0000, SHALL be the PC value loaded on reset.
REQ-002 Parameter TIMEOUT_CYCLES, default 15, SHALL be the maximum wait for mem_ack before a fetch error; it applies only when FETCH_TIMEOUT_EN is defined.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 enable  input  1  SHALL request that fetching run.
REQ-006 stall  input  1  SHALL be asserted by the decode stage to hold the current instruction.
REQ-007 redirect  input  1  SHALL request a branch/jump target load.
REQ-008 redirect_pc  input  32  SHALL be the branch/jump target.
REQ-009 mem_ack  input  1  SHALL indicate mem_rdata is valid this cycle.
REQ-010 mem_rdata  input  32  SHALL carry the instruction word from memory.
REQ-011 mem_req  output  1  SHALL request an instruction read.
REQ-012 mem_addr  output  32  SHALL carry the fetch address, equal to pc.
REQ-013 instr  output  32  SHALL be the instruction register.
REQ-014 opcode  output  6  SHALL equal instr[31:26].
REQ-015 funct  output  6  SHALL equal instr[5:0].
REQ-016 rs, rt, rd  output  5 each  SHALL equal instr[25:21], instr[20:16] and instr[15:11].
REQ-017 imm16  output  16  SHALL equal instr[15:0].
REQ-018 instr_valid  output  1  SHALL be high while instr holds an unconsumed instruction.
REQ-019 pc  output  32  SHALL be the address of instr or of the pending fetch.
REQ-020 pc_plus4  output  32  SHALL equal pc+4, combinational.
REQ-021 fetch_err  output  1  SHALL be a one-cycle timeout error pulse.

Function
REQ-022 The FSM SHALL have the states IDLE, FETCH and VALID.
REQ-023 IDLE: mem_req=0; when enable=1, the FSM SHALL move to FETCH on the next edge.
REQ-024 FETCH: the block SHALL hold mem_req=1 and mem_addr=pc until mem_ack.
- On mem_ack: instr<=mem_rdata, instr_valid<=1, next state VALID.
- Zero-wait ack in the first FETCH cycle SHALL be accepted.
REQ-025 VALID, stall=1 and redirect=0: instr, pc and instr_valid SHALL hold and mem_req SHALL be 0.
REQ-026 VALID, stall=0: the instruction is consumed.
- pc<=pc+4 and instr_valid<=0.
- Next state FETCH if enable=1, else IDLE.
REQ-027 redirect=1 in any non-IDLE state SHALL take priority over stall and mem_ack.
- pc<={redirect_pc[31:2],2'b00} and instr_valid<=0; next state FETCH.
- A mem_ack in the same cycle SHALL be discarded, with instr unchanged.
REQ-028 redirect=1 in IDLE SHALL load pc and remain in IDLE.
REQ-029 enable deassertion during FETCH SHALL NOT abort the fetch; the block SHALL complete it, then go to VALID.
REQ-030 pc arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000.
REQ-031 Fetch-to-valid latency SHALL be 1 cycle after the mem_ack edge.
REQ-032 The steady-state throughput SHALL be one instruction per 2 cycles with zero-wait memory.
REQ-033 The decoded field outputs SHALL be combinational from instr.

Reset
REQ-034 On reset: state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, mem_req=0, fetch_err=0, timeout counter=0.
REQ-035 Reset mid-fetch SHALL drop mem_req immediately and discard any later mem_ack.

Configuration
REQ-036 With FETCH_TIMEOUT_EN defined, a 4-bit counter SHALL run while in FETCH.
- The counter SHALL clear on entry to FETCH and on mem_ack.
- When it reaches TIMEOUT_CYCLES without ack: fetch_err pulses for 1 cycle, the counter clears, and the block re-issues the fetch at the same pc.
REQ-037 Without FETCH_TIMEOUT_EN, no counter SHALL exist, fetch_err SHALL be tied to 0, and FETCH SHALL wait indefinitely.

Verification
REQ-038 Reset then enable=1 with zero-wait memory returning 32'h2008_0005 -> mem_addr=32'h0040_0000; instr_valid=1 one cycle later; opcode=6'h08, rt=8, imm16=16'h0005.
REQ-039 A 3-cycle mem_ack delay -> mem_req high for 4 cycles with constant mem_addr; instr captured only on the ack edge.
REQ-040 stall=1 for 5 cycles in VALID -> instr, pc and instr_valid stable, mem_req=0; on release, pc advances by 4.
REQ-041 redirect=1 with redirect_pc=32'h0040_0103 while stall=1 -> pc=32'h0040_0100, instr_valid=0, next fetch at 32'h0040_0100; a simultaneous ack is ignored.
REQ-042 pc=32'hFFFF_FFFC consumed -> next mem_addr=32'h0000_0000.
REQ-043 With FETCH_TIMEOUT_EN defined and no ack for 15 cycles -> fetch_err pulse and the fetch is retried at the same address; without the macro -> fetch_err stays 0.

Source files
------------

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - instruction fetch stage: PC, memory request FSM, instruction register and field decode
// Optional fetch timeout/retry is built when FETCH_TIMEOUT_EN is defined.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC       = 32'h0040_0000,
    parameter int          TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm16,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } state_t;

    // The timeout counter is 4 bits wide, so the limit must fit in it.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 15) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..15");
    end

    state_t      state, state_next;
    logic [31:0] pc_next, instr_next, redirect_aligned;
    logic        valid_next;

    assign redirect_aligned = {redirect_pc[31:2], 2'b00};
    assign pc_plus4         = pc + 32'd4;
    assign mem_req          = (state == FETCH);
    assign mem_addr         = pc;

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign funct  = instr[5:0];
    assign imm16  = instr[15:0];

`ifdef FETCH_TIMEOUT_EN
    localparam logic [3:0] TIMEOUT_LAST = 4'(TIMEOUT_CYCLES - 1);

    logic [3:0] timeout_cnt, cnt_next;
    logic       err_next;
`endif

    always_comb begin
        state_next = state;
        pc_next    = pc;
        instr_next = instr;
        valid_next = instr_valid;
`ifdef FETCH_TIMEOUT_EN
        cnt_next   = 4'd0;
        err_next   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (redirect) begin
                    pc_next = redirect_aligned;
                end else if (enable) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                // A redirect wins over a same-cycle ack; the returned word is dropped.
                if (redirect) begin
                    pc_next    = redirect_aligned;
                    valid_next = 1'b0;
                end else if (mem_ack) begin
                    instr_next = mem_rdata;
                    valid_next = 1'b1;
                    state_next = VALID;
                end else begin
`ifdef FETCH_TIMEOUT_EN
                    if (timeout_cnt == TIMEOUT_LAST) begin
                        err_next = 1'b1;
                    end else begin
                        cnt_next = timeout_cnt + 4'd1;
                    end
`endif
                end
            end
            VALID: begin
                if (redirect) begin
                    pc_next    = redirect_aligned;
                    valid_next = 1'b0;
                    state_next = FETCH;
                end else if (!stall) begin
                    pc_next    = pc_plus4;
                    valid_next = 1'b0;
                    state_next = enable ? FETCH : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= 32'd0;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            instr       <= instr_next;
            instr_valid <= valid_next;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_cnt <= 4'd0;
            fetch_err   <= 1'b0;
        end else begin
            timeout_cnt <= cnt_next;
            fetch_err   <= err_next;
        end
    end
`else
    assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch
module tb_instruction_fetch;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset, enable, stall, redirect, mem_ack;
    logic [31:0] redirect_pc, mem_rdata;
    logic        mem_req, instr_valid, fetch_err;
    logic [31:0] mem_addr, instr, pc, pc_plus4;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm16;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;
        int          delay;
    } vec_t;

    vec_t vecs[3];

    instruction_fetch #(.RESET_PC(RESET_PC), .TIMEOUT_CYCLES(15)) dut (
        .clk(clk), .reset(reset), .enable(enable), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .instr(instr),
        .opcode(opcode), .funct(funct), .rs(rs), .rt(rt), .rd(rd),
        .imm16(imm16), .instr_valid(instr_valid), .pc(pc),
        .pc_plus4(pc_plus4), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in the first FETCH cycle; leaves the DUT in VALID holding the word.
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] word, input int delay);
        logic [31:0] held, exp;
        held = instr;
        chk("fetch_req", 32'(mem_req), 32'd1);
        chk("fetch_addr", mem_addr, addr);
        chk("pc_plus4", pc_plus4, addr + 32'd4);
        for (int d = 0; d < delay; d++) begin
            step();
            chk("wait_req", 32'(mem_req), 32'd1);
            chk("wait_addr", mem_addr, addr);
            chk("wait_instr_hold", instr, held);
            chk("wait_valid", 32'(instr_valid), 32'd0);
        end
        mem_ack   = 1'b1;
        mem_rdata = word;
        exp_q.push_back(word);
        step();
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        exp = exp_q.pop_front();
        chk("valid_set", 32'(instr_valid), 32'd1);
        chk("valid_req_low", 32'(mem_req), 32'd0);
        chk("instr", instr, exp);
        chk("opcode", 32'(opcode), 32'(exp[31:26]));
        chk("rs", 32'(rs), 32'(exp[25:21]));
        chk("rt", 32'(rt), 32'(exp[20:16]));
        chk("rd", 32'(rd), 32'(exp[15:11]));
        chk("funct", 32'(funct), 32'(exp[5:0]));
        chk("imm16", 32'(imm16), 32'(exp[15:0]));
        chk("valid_pc", pc, addr);
    endtask

    initial begin
        logic [31:0] held;
        logic        exp_err;

        vecs[0] = '{addr: 32'h0040_0004, word: 32'h8C43_0004, delay: 3};
        vecs[1] = '{addr: 32'h0040_0008, word: 32'h014B_4820, delay: 1};
        vecs[2] = '{addr: 32'h0040_000C, word: 32'hAFBF_0010, delay: 2};

        reset = 1'b1; enable = 1'b0; stall = 1'b0; redirect = 1'b0;
        redirect_pc = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
        step();
        step();
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_pc", pc, RESET_PC);
        chk("rst_instr", instr, 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_err", 32'(fetch_err), 32'd0);
        reset = 1'b0;
        step();
        chk("idle_req", 32'(mem_req), 32'd0);

        // First fetch, zero-wait memory.
        enable = 1'b1;
        step();
        do_fetch(32'h0040_0000, 32'h2008_0005, 0);
        chk("first_opcode", 32'(opcode), 32'h08);
        chk("first_rt", 32'(rt), 32'd8);
        chk("first_imm16", 32'(imm16), 32'h0005);
        step();

        for (int i = 0; i < 3; i++) begin
            do_fetch(vecs[i].addr, vecs[i].word, vecs[i].delay);
            step();
        end

        // Stall holds the instruction for 5 cycles.
        stall = 1'b1;
        do_fetch(32'h0040_0010, 32'h3C01_1001, 0);
        held = instr;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_instr", instr, held);
            chk("stall_pc", pc, 32'h0040_0010);
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_req", 32'(mem_req), 32'd0);
        end
        stall = 1'b0;
        step();
        chk("release_pc", pc, 32'h0040_0014);
        chk("release_req", 32'(mem_req), 32'd1);
        chk("release_valid", 32'(instr_valid), 32'd0);

        // Redirect during stall, with an ack in the same cycle.
        stall = 1'b1;
        do_fetch(32'h0040_0014, 32'h0085_1020, 0);
        step();
        redirect = 1'b1; redirect_pc = 32'h0040_0103;
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        step();
        redirect = 1'b0; mem_ack = 1'b0;
        chk("redir_pc", pc, 32'h0040_0100);
        chk("redir_valid", 32'(instr_valid), 32'd0);
        chk("redir_req", 32'(mem_req), 32'd1);
        chk("redir_addr", mem_addr, 32'h0040_0100);
        chk("redir_instr", instr, 32'h0085_1020);

        // Redirect in FETCH beats a simultaneous ack.
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        mem_ack = 1'b1; mem_rdata = 32'hBAAD_F00D;
        step();
        redirect = 1'b0; mem_ack = 1'b0;
        stall = 1'b0;
        chk("redir_f_pc", pc, 32'hFFFF_FFFC);
        chk("redir_f_valid", 32'(instr_valid), 32'd0);
        chk("redir_f_instr", instr, 32'h0085_1020);
        chk("redir_f_req", 32'(mem_req), 32'd1);

        // PC wrap at the top of the address space.
        do_fetch(32'hFFFF_FFFC, 32'h0800_0000, 1);
        step();
        chk("wrap_addr", mem_addr, 32'h0000_0000);
        chk("wrap_req", 32'(mem_req), 32'd1);

        // Dropping enable mid-fetch still completes the fetch.
        enable = 1'b0;
        do_fetch(32'h0000_0000, 32'h2442_0001, 2);
        step();
        chk("noen_req", 32'(mem_req), 32'd0);
        chk("noen_pc", pc, 32'h0000_0004);
        chk("noen_valid", 32'(instr_valid), 32'd0);
        step();
        chk("noen_idle", 32'(mem_req), 32'd0);

        // Redirect while idle loads pc only.
        redirect = 1'b1; redirect_pc = 32'h0000_1237;
        step();
        redirect = 1'b0;
        chk("idle_redir_pc", pc, 32'h0000_1234);
        chk("idle_redir_req", 32'(mem_req), 32'd0);
        step();
        chk("idle_redir_stay", 32'(mem_req), 32'd0);

        // Long wait without ack.
        enable = 1'b1;
        step();
        for (int i = 1; i <= 20; i++) begin
            step();
`ifdef FETCH_TIMEOUT_EN
            exp_err = (i == 15);
`else
            exp_err = 1'b0;
`endif
            chk("to_err", 32'(fetch_err), 32'(exp_err));
            chk("to_req", 32'(mem_req), 32'd1);
            chk("to_addr", mem_addr, 32'h0000_1234);
        end
        do_fetch(32'h0000_1234, 32'h1111_2222, 0);
        step();

        // Asynchronous reset in the middle of a fetch.
        chk("pre_rst_req", 32'(mem_req), 32'd1);
        reset = 1'b1;
        #1;
        chk("async_rst_req", 32'(mem_req), 32'd0);
        chk("async_rst_pc", pc, RESET_PC);
        chk("async_rst_valid", 32'(instr_valid), 32'd0);
        chk("async_rst_instr", instr, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        step();
        enable = 1'b0;
        reset  = 1'b0;
        step();
        mem_ack = 1'b0;
        chk("post_rst_instr", instr, 32'd0);
        chk("post_rst_valid", 32'(instr_valid), 32'd0);
        chk("post_rst_req", 32'(mem_req), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
